l2_bus_arbiter_2port: RTL and testbench
=======================================

Name: l2_bus_arbiter_2port

Overview:
- Sits between the two L1 caches' miss handlers (port 0 = instruction cache, port 1 = data cache) and the single shared L2 memory port.
- Decides which L1 owns the L2 bus and returns the `l2_bus_arbiter_rd_granted` / `l2_bus_arbiter_wr_granted` signals that each L1 cache consumes.
- Steers the owner's address, write data and enables to L2; broadcasts L2 read data back to both L1 caches.
- Grants are round-robin and held for the whole transaction, so a 4-word line fill or a write-through is never split.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- MAX_HOLD, 16, cycles of continuous ownership after which the timeout flag is raised.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- p0_mem_en  in  1  port 0 requests the bus (that cache's l2_mem_en).
- p0_mem_wr_en  in  1  port 0 request is a write.
- p0_addr  in  ADDR_W  port 0 access address.
- p0_wr_data  in  DATA_W  port 0 write data.
- p0_rd_granted  out  1  port 0 owns the bus for a read.
- p0_wr_granted  out  1  port 0 owns the bus for a write.
- p1_mem_en, p1_mem_wr_en, p1_addr, p1_wr_data, p1_rd_granted, p1_wr_granted: same as port 0, for port 1.
- rd_data  out  DATA_W  l2_rd_data broadcast to both ports.
- l2_en  out  1  L2 access enable.
- l2_wr_en  out  1  L2 write enable.
- l2_addr  out  ADDR_W  L2 address.
- l2_wr_data  out  DATA_W  L2 write data.
- l2_rd_data  in  DATA_W  L2 read data, valid one cycle after the address (synchronous SRAM).
- hold_timeout  out  1  sticky flag: one ownership exceeded MAX_HOLD cycles.

Behaviour:
- States: IDLE, OWN0, OWN1. State is held in a register.
- Registered state: state, last_owner (1 bit), hold_cnt (clog2(MAX_HOLD+1) bits), hold_timeout.
- Reset values: state = IDLE, last_owner = 1 (so port 0 wins the first tie), hold_cnt = 0, hold_timeout = 0.
- Outputs during reset: all grants 0, l2_en = 0, l2_wr_en = 0, l2_addr = 0, l2_wr_data = 0.
- Next-state rules, evaluated every cycle from the current requests:
  - Owner still requesting: keep the owner.
  - Owner released (or IDLE) and exactly one port requesting: grant that port.
  - Both requesting: grant the port not equal to last_owner.
  - Nobody requesting: go to IDLE.
- Latency: a request seen in cycle N is granted from cycle N+1. Release to a new grant also takes one cycle, with no idle bubble required.
- last_owner is updated on every transition into OWN0 or OWN1.
- Grant outputs are decoded from state; the read/write split is combinational from the owner's mem_wr_en:
  - pX_wr_granted = (state == OWNX) & pX_mem_wr_en.
  - pX_rd_granted = (state == OWNX) & !pX_mem_wr_en.
- L2 outputs are a combinational mux of the owner's signals:
  - l2_en = owner mem_en; l2_wr_en = owner mem_en & owner mem_wr_en.
  - l2_addr and l2_wr_data follow the owner.
  - In IDLE, all L2 outputs are 0.
- A non-owner's request never reaches L2.
- The owner may toggle wr_en mid-ownership (write-back then fill). Grant type follows immediately; ownership is kept.
- hold_cnt:
  - Clears on every ownership change and in IDLE.
  - Otherwise increments while owned and saturates at MAX_HOLD.
  - When it reaches MAX_HOLD while the other port is requesting, hold_timeout is set; it clears only on rst.
  - Timeout is diagnostic only: there is no pre-emption.
- Owner drops mem_en in the same cycle the other port raises its request: the other port is granted next cycle, regardless of last_owner.
- rst asserted mid-transaction: all state and outputs go to reset values immediately (asynchronously). In-flight transactions are abandoned; the L1 miss handlers re-request after reset.
- rd_data = l2_rd_data unregistered. Each L1 qualifies it with its own grant history.

Decomposition:
- Shared package l2_bus_pkg:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_OWN0, ARB_OWN1}.
  - localparams PORT_ICACHE = 0 and PORT_DCACHE = 1.
  - Default ADDR_W and DATA_W.
- One natural sub-module, l2_arb_rr_pick: a combinational round-robin picker. Inputs are the request vector, last_owner and current owner; outputs are the next owner and a valid bit. The FSM, counters and data mux stay in the top level.

Test Plan:
- Reset then p0_mem_en = 1, p0_addr = 0x0000_1000, read -> p0_rd_granted = 1 from the next cycle; l2_addr = 0x0000_1000, l2_en = 1, l2_wr_en = 0; p1 grants stay 0.
- Both ports raise requests in the same cycle after reset -> port 0 granted first. Port 0 drops after 4 cycles -> port 1 granted in the very next cycle. Port 1 drops and both re-request -> port 0 granted (round-robin).
- Port 1 writes with p1_wr_data = 0xDEAD_BEEF, then switches to a read while still holding mem_en -> p1_wr_granted goes 1 to 0, p1_rd_granted goes 0 to 1 in the same cycle; state stays OWN1; l2_wr_data = 0xDEAD_BEEF during the write cycles.
- Port 0 holds the bus for 20 cycles while port 1 requests throughout -> hold_timeout = 1 at cycle MAX_HOLD (16) of ownership and stays 1 after both release; port 1 is still granted after port 0 releases.
- rst pulsed for one cycle while OWN1 with port 1 writing -> all grants, l2_en and l2_wr_en are 0 during reset with no wait for a clock edge. With both still requesting afterwards, port 0 is granted first.
- Port 0 requests only after port 1 has released into IDLE -> port 0 granted one cycle later; l2_en is 0 in the IDLE cycle.

Source files
------------

// File: rtl/l2_bus_pkg.sv
// Shared types and defaults for the two-port L2 bus arbiter.
package l2_bus_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   localparam int PORT_ICACHE = 0;
   localparam int PORT_DCACHE = 1;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   // Index of the owning port for an owned state (ARB_OWN1 -> 1, otherwise 0).
   function automatic logic owner_of(arb_state_t s);
      return (s == ARB_OWN1);
   endfunction

endpackage

// File: rtl/l2_arb_rr_pick.sv
// Combinational round-robin picker: keeps a requesting owner, otherwise
// grants the sole requester, or on a tie the port that did not own last.
module l2_arb_rr_pick
   import l2_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   input  logic       cur_valid,
   input  logic       cur_owner,
   output logic       next_owner,
   output logic       next_valid
);

   // Pick the next bus owner from the current requests.
   always_comb begin
      next_owner = 1'b0;
      next_valid = 1'b0;
      if (cur_valid && req[cur_owner]) begin
         next_owner = cur_owner;
         next_valid = 1'b1;
      end else begin
         case (req)
            2'b01: begin
               next_owner = 1'(PORT_ICACHE);
               next_valid = 1'b1;
            end
            2'b10: begin
               next_owner = 1'(PORT_DCACHE);
               next_valid = 1'b1;
            end
            2'b11: begin
               next_owner = ~last_owner;
               next_valid = 1'b1;
            end
            default: begin
               next_owner = 1'b0;
               next_valid = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/l2_bus_arbiter_2port.sv
// Two-port L2 bus arbiter: I-cache (port 0) and D-cache (port 1) share one
// synchronous L2 port. Ownership is round-robin and held for as long as the
// owner keeps mem_en high, so multi-beat fills and write-throughs stay whole.
module l2_bus_arbiter_2port
   import l2_bus_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_mem_en,
   input  logic              p0_mem_wr_en,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wr_data,
   output logic              p0_rd_granted,
   output logic              p0_wr_granted,
   input  logic              p1_mem_en,
   input  logic              p1_mem_wr_en,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wr_data,
   output logic              p1_rd_granted,
   output logic              p1_wr_granted,
   output logic [DATA_W-1:0] rd_data,
   output logic              l2_en,
   output logic              l2_wr_en,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [DATA_W-1:0] l2_wr_data,
   input  logic [DATA_W-1:0] l2_rd_data,
   output logic              hold_timeout
);

   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);

   arb_state_t       state;
   arb_state_t       state_next;
   logic             last_owner;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_cnt_next;
   logic             timeout_set;
   logic             owner_change;
   logic             other_req;
   logic             cur_valid;
   logic             cur_owner;
   logic             pick_owner;
   logic             pick_valid;

   assign cur_valid = (state != ARB_IDLE);
   assign cur_owner = owner_of(state);

   l2_arb_rr_pick u_pick (
      .req        ({p1_mem_en, p0_mem_en}),
      .last_owner (last_owner),
      .cur_valid  (cur_valid),
      .cur_owner  (cur_owner),
      .next_owner (pick_owner),
      .next_valid (pick_valid)
   );

   // State, round-robin history, hold counter and sticky timeout registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ARB_IDLE;
         last_owner   <= 1'b1;
         hold_cnt     <= '0;
         hold_timeout <= 1'b0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_cnt_next;
         if (owner_change) begin
            last_owner <= pick_owner;
         end
         if (timeout_set) begin
            hold_timeout <= 1'b1;
         end
      end
   end

   // Next state, hold-count update and timeout detection.
   always_comb begin
      state_next    = ARB_IDLE;
      owner_change  = 1'b0;
      hold_cnt_next = '0;
      timeout_set   = 1'b0;
      other_req     = cur_owner ? p0_mem_en : p1_mem_en;
      if (pick_valid) begin
         state_next   = pick_owner ? ARB_OWN1 : ARB_OWN0;
         owner_change = !cur_valid || (pick_owner != cur_owner);
      end
      if (pick_valid && !owner_change) begin
         hold_cnt_next = (hold_cnt < CNT_MAX) ? hold_cnt + CNT_W'(1) : hold_cnt;
         timeout_set   = (hold_cnt_next == CNT_MAX) && other_req;
      end
   end

   // Grant decode and L2 steering from the owner's signals; all zero in IDLE.
   always_comb begin
      p0_rd_granted = 1'b0;
      p0_wr_granted = 1'b0;
      p1_rd_granted = 1'b0;
      p1_wr_granted = 1'b0;
      l2_en         = 1'b0;
      l2_wr_en      = 1'b0;
      l2_addr       = '0;
      l2_wr_data    = '0;
      case (state)
         ARB_OWN0: begin
            p0_rd_granted = !p0_mem_wr_en;
            p0_wr_granted = p0_mem_wr_en;
            l2_en         = p0_mem_en;
            l2_wr_en      = p0_mem_en & p0_mem_wr_en;
            l2_addr       = p0_addr;
            l2_wr_data    = p0_wr_data;
         end
         ARB_OWN1: begin
            p1_rd_granted = !p1_mem_wr_en;
            p1_wr_granted = p1_mem_wr_en;
            l2_en         = p1_mem_en;
            l2_wr_en      = p1_mem_en & p1_mem_wr_en;
            l2_addr       = p1_addr;
            l2_wr_data    = p1_wr_data;
         end
         default: begin
            l2_en = 1'b0;
         end
      endcase
   end

   // Read data goes straight back to both caches; each qualifies it itself.
   assign rd_data = l2_rd_data;

endmodule

// File: tb/tb_l2_bus_arbiter_2port.sv
// Self-checking bench for l2_bus_arbiter_2port. Each cycle the expected
// output vector is pushed when stimulus is driven and popped for comparison.
module tb_l2_bus_arbiter_2port;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int MAX_HOLD = 16;
   localparam int VEC_W    = 6 + ADDR_W + DATA_W;

   typedef struct {
      int   own;   // 0 = idle, 1 = port 0 owns, 2 = port 1 owns
      logic e0;
      logic w0;
      logic e1;
      logic w1;
   } step_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              p0_mem_en = 1'b0, p0_mem_wr_en = 1'b0;
   logic [ADDR_W-1:0] p0_addr = '0;
   logic [DATA_W-1:0] p0_wr_data = '0;
   logic              p0_rd_granted, p0_wr_granted;
   logic              p1_mem_en = 1'b0, p1_mem_wr_en = 1'b0;
   logic [ADDR_W-1:0] p1_addr = '0;
   logic [DATA_W-1:0] p1_wr_data = '0;
   logic              p1_rd_granted, p1_wr_granted;
   logic [DATA_W-1:0] rd_data;
   logic              l2_en, l2_wr_en;
   logic [ADDR_W-1:0] l2_addr;
   logic [DATA_W-1:0] l2_wr_data;
   logic [DATA_W-1:0] l2_rd_data = '0;
   logic              hold_timeout;

   int n_cmp = 0;
   int n_bad = 0;
   logic [VEC_W-1:0] sb [$];

   l2_bus_arbiter_2port #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .p0_mem_en     (p0_mem_en),
      .p0_mem_wr_en  (p0_mem_wr_en),
      .p0_addr       (p0_addr),
      .p0_wr_data    (p0_wr_data),
      .p0_rd_granted (p0_rd_granted),
      .p0_wr_granted (p0_wr_granted),
      .p1_mem_en     (p1_mem_en),
      .p1_mem_wr_en  (p1_mem_wr_en),
      .p1_addr       (p1_addr),
      .p1_wr_data    (p1_wr_data),
      .p1_rd_granted (p1_rd_granted),
      .p1_wr_granted (p1_wr_granted),
      .rd_data       (rd_data),
      .l2_en         (l2_en),
      .l2_wr_en      (l2_wr_en),
      .l2_addr       (l2_addr),
      .l2_wr_data    (l2_wr_data),
      .l2_rd_data    (l2_rd_data),
      .hold_timeout  (hold_timeout)
   );

   always #5 clk = ~clk;

   // Expected {p0_rd,p0_wr,p1_rd,p1_wr,l2_en,l2_wr_en,l2_addr,l2_wr_data}
   // given the hand-derived owner of this cycle and the driven inputs.
   function automatic logic [VEC_W-1:0] exp_vec(input int own);
      logic [VEC_W-1:0] v;
      v = '0;
      if (own == 1)
         v = {!p0_mem_wr_en, p0_mem_wr_en, 2'b00, p0_mem_en,
              p0_mem_en & p0_mem_wr_en, p0_addr, p0_wr_data};
      else if (own == 2)
         v = {2'b00, !p1_mem_wr_en, p1_mem_wr_en, p1_mem_en,
              p1_mem_en & p1_mem_wr_en, p1_addr, p1_wr_data};
      return v;
   endfunction

   function automatic logic [VEC_W-1:0] obs_vec();
      return {p0_rd_granted, p0_wr_granted, p1_rd_granted, p1_wr_granted,
              l2_en, l2_wr_en, l2_addr, l2_wr_data};
   endfunction

   // Drive one cycle of requests just after the edge and queue the expectation.
   task automatic cyc(input step_t s);
      @(posedge clk);
      #1;
      p0_mem_en    = s.e0;
      p0_mem_wr_en = s.w0;
      p1_mem_en    = s.e1;
      p1_mem_wr_en = s.w1;
      sb.push_back(exp_vec(s.own));
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst          = 1'b1;
      p0_mem_en    = 1'b0;
      p1_mem_en    = 1'b0;
      p0_mem_wr_en = 1'b0;
      p1_mem_wr_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [VEC_W-1:0] e;
      p0_mem_en = 1'b1; p1_mem_en = 1'b1; p1_mem_wr_en = 1'b1;
      p0_addr = 32'h0000_0AAA; p1_addr = 32'h0000_0BBB;
      repeat (3) @(posedge clk);
      #2;
      sb.push_back('0);
      e = sb.pop_front();
      n_cmp++;
      if (obs_vec() !== e) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected %h", obs_vec(), e);
      end
      n_cmp++;
      if (hold_timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_timeout: got %b expected 0", hold_timeout);
      end
      p0_mem_en = 1'b0; p1_mem_en = 1'b0; p1_mem_wr_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      step_t st [5] = '{'{0,1,0,0,0}, '{1,1,0,0,0}, '{1,1,0,0,0},
                        '{1,0,0,0,0}, '{0,0,0,0,0}};
      logic [VEC_W-1:0] e;
      p0_addr = 32'h0000_1000; p0_wr_data = 32'h0000_00A0;
      p1_addr = 32'h0000_2000; p1_wr_data = 32'h0000_00B0;
      for (int i = 0; i < 5; i++) begin
         cyc(st[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs_vec() !== e) begin
            n_bad++;
            $display("FAIL single_read[%0d]: got %h expected %h", i, obs_vec(), e);
         end
      end
   endtask

   task automatic test_round_robin();
      step_t st [13] = '{'{0,1,0,1,0}, '{1,1,0,1,0}, '{1,1,0,1,0}, '{1,1,0,1,0},
                         '{1,1,0,1,0}, '{1,0,0,1,0}, '{2,0,0,1,0}, '{2,0,0,1,0},
                         '{2,0,0,0,0}, '{0,1,0,1,0}, '{1,1,0,1,0}, '{1,0,0,0,0},
                         '{0,0,0,0,0}};
      logic [VEC_W-1:0] e;
      do_reset();
      p0_addr = 32'h0000_0100; p0_wr_data = 32'h0000_0011;
      p1_addr = 32'h0000_0200; p1_wr_data = 32'h0000_0022;
      for (int i = 0; i < 13; i++) begin
         cyc(st[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs_vec() !== e) begin
            n_bad++;
            $display("FAIL round_robin[%0d]: got %h expected %h", i, obs_vec(), e);
         end
      end
   endtask

   task automatic test_write_then_read();
      step_t st [7] = '{'{0,0,0,1,1}, '{2,0,0,1,1}, '{2,0,0,1,1}, '{2,0,0,1,0},
                        '{2,0,0,1,0}, '{2,0,0,0,0}, '{0,0,0,0,0}};
      logic [VEC_W-1:0] e;
      logic [DATA_W-1:0] rexp;
      p1_addr = 32'h0000_3340; p1_wr_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 7; i++) begin
         cyc(st[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs_vec() !== e) begin
            n_bad++;
            $display("FAIL write_then_read[%0d]: got %h expected %h", i, obs_vec(), e);
         end
         rexp = 32'hCAFE_0000 + DATA_W'(i);
         l2_rd_data = rexp;
         #1;
         n_cmp++;
         if (rd_data !== rexp) begin
            n_bad++;
            $display("FAIL rd_data[%0d]: got %h expected %h", i, rd_data, rexp);
         end
      end
   endtask

   task automatic test_hold_timeout();
      step_t s;
      logic [VEC_W-1:0] e;
      p0_addr = 32'h0000_4000; p1_addr = 32'h0000_5000;
      for (int i = 0; i < 25; i++) begin
         if (i == 0)       s = '{0,1,0,0,0};
         else if (i <= 20) s = '{1,1,0,1,0};
         else if (i == 21) s = '{1,0,0,1,0};
         else if (i == 22) s = '{2,0,0,1,0};
         else if (i == 23) s = '{2,0,0,0,0};
         else              s = '{0,0,0,0,0};
         cyc(s);
         e = sb.pop_front();
         n_cmp++;
         if (obs_vec() !== e) begin
            n_bad++;
            $display("FAIL hold[%0d]: got %h expected %h", i, obs_vec(), e);
         end
         if (i == 11) begin
            n_cmp++;
            if (hold_timeout !== 1'b0) begin
               n_bad++;
               $display("FAIL timeout_early: got %b expected 0", hold_timeout);
            end
         end
         if (i == 20 || i == 24) begin
            n_cmp++;
            if (hold_timeout !== 1'b1) begin
               n_bad++;
               $display("FAIL timeout_set[%0d]: got %b expected 1", i, hold_timeout);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      step_t pre [3] = '{'{0,0,0,1,1}, '{2,1,0,1,1}, '{2,1,0,1,1}};
      step_t post [4] = '{'{1,1,0,1,1}, '{1,1,0,1,1}, '{1,0,0,0,0}, '{0,0,0,0,0}};
      logic [VEC_W-1:0] e;
      p0_addr = 32'h0000_6000; p1_addr = 32'h0000_7000; p1_wr_data = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         cyc(pre[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs_vec() !== e) begin
            n_bad++;
            $display("FAIL pre_reset[%0d]: got %h expected %h", i, obs_vec(), e);
         end
      end
      #2;
      rst = 1'b1;
      #1;
      sb.push_back('0);
      e = sb.pop_front();
      n_cmp++;
      if (obs_vec() !== e) begin
         n_bad++;
         $display("FAIL async_reset_outputs: got %h expected %h", obs_vec(), e);
      end
      n_cmp++;
      if (hold_timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset_timeout: got %b expected 0", hold_timeout);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      sb.push_back(exp_vec(0));
      e = sb.pop_front();
      n_cmp++;
      if (obs_vec() !== e) begin
         n_bad++;
         $display("FAIL after_reset_idle: got %h expected %h", obs_vec(), e);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(post[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs_vec() !== e) begin
            n_bad++;
            $display("FAIL post_reset[%0d]: got %h expected %h", i, obs_vec(), e);
         end
      end
   endtask

   task automatic test_idle_gap();
      step_t st [8] = '{'{0,0,0,1,0}, '{2,0,0,1,0}, '{2,0,0,0,0}, '{0,0,0,0,0},
                        '{0,1,0,0,0}, '{1,1,0,0,0}, '{1,0,0,0,0}, '{0,0,0,0,0}};
      logic [VEC_W-1:0] e;
      p0_addr = 32'h0000_8000; p1_addr = 32'h0000_9000;
      for (int i = 0; i < 8; i++) begin
         cyc(st[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs_vec() !== e) begin
            n_bad++;
            $display("FAIL idle_gap[%0d]: got %h expected %h", i, obs_vec(), e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_then_read();
      test_hold_timeout();
      test_async_reset();
      test_idle_gap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
